// File: rtl/aes_pkg.sv
// Shared AES-core definitions used by the S-box arbiter and its tag pipe.
//   AES_STATE_W / AES_WORD_W : widths of a full AES state and one key word
//   req_id_t                 : which requester issued an S-box operation
//   sbox_tag_t               : one in-flight tag {vld, id}
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic {
    ID_RD = 1'b0,
    ID_KS = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } sbox_tag_t;

endpackage

// File: rtl/sbox_arbiter_if.sv
// Request/response bundle between the two S-box requesters and the arbiter.
//   master : requester side (round datapath + key expansion)
//   slave  : arbiter side
// Round datapath: rd_req_* (128-bit state in), rd_rsp_* (128-bit state out).
// Key expansion : ks_req_* (32-bit word in),   ks_rsp_* (32-bit word out).
interface sbox_arbiter_if;

  logic                             rd_req_valid;
  logic                             rd_req_ready;
  logic [aes_pkg::AES_STATE_W-1:0]  rd_req_data;
  logic                             rd_rsp_valid;
  logic [aes_pkg::AES_STATE_W-1:0]  rd_rsp_data;

  logic                             ks_req_valid;
  logic                             ks_req_ready;
  logic [aes_pkg::AES_WORD_W-1:0]   ks_req_word;
  logic                             ks_rsp_valid;
  logic [aes_pkg::AES_WORD_W-1:0]   ks_rsp_word;

  modport master (
    output rd_req_valid, rd_req_data, ks_req_valid, ks_req_word,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  ks_req_ready, ks_rsp_valid, ks_rsp_word
  );

  modport slave (
    input  rd_req_valid, rd_req_data, ks_req_valid, ks_req_word,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output ks_req_ready, ks_rsp_valid, ks_rsp_word
  );

endinterface

// File: rtl/sbox_tag_pipe.sv
// DEPTH-stage shift register of {vld, id} tags that runs alongside the
// registered S-box so each result can be routed back to its issuer.
//   clk, rst_n : clock, asynchronous active-low clear
//   i_tag      : tag of the operation entering the S-box this cycle
//   o_tag      : tag of the result leaving the S-box this cycle
module sbox_tag_pipe
  import aes_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sbox_tag_t i_tag,
  output sbox_tag_t o_tag
);

  sbox_tag_t r_stage [DEPTH];

  // NOTE: every stage is cleared; a stale vld bit surviving reset would
  // emit a response pulse for an operation that was discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's old value.
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one registered 128-bit S-box between the round datapath (SubBytes
// on a full state) and the key-expansion unit (SubWord on one word).
// Round-robin on contention, tag pipe matched to the S-box latency.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester handshakes and responses (slave side)
//   sb_in    : operand to the S-box (0 when nothing is granted)
//   sb_out   : S-box result, valid SBOX_LAT cycles after sb_in is sampled
// SBOX_LAT must lie in 1..4.
module sbox_arbiter
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sbox_arbiter_if.slave          bus,
  output logic [AES_STATE_W-1:0] sb_in,
  input  logic [AES_STATE_W-1:0] sb_out
);

  req_id_t   r_ptr;
  logic      w_grant_rd;
  logic      w_grant_ks;
  logic      w_contested;
  sbox_tag_t w_tag_in;
  sbox_tag_t w_tag_out;

  // Grants are gated with rst so no handshake completes while reset is held.
  assign w_contested = rst && bus.rd_req_valid && bus.ks_req_valid;

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    w_grant_rd = 1'b0;
    w_grant_ks = 1'b0;
    if (w_contested) begin
      if (r_ptr == ID_KS) w_grant_ks = 1'b1;
      else                w_grant_rd = 1'b1;
    end else if (rst) begin
      w_grant_rd = bus.rd_req_valid;
      w_grant_ks = bus.ks_req_valid;
    end
  end

  // Pointer only moves on a contested grant, to the requester that lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= ID_KS;
    end else if (w_contested) begin
      r_ptr <= w_grant_ks ? ID_RD : ID_KS;
    end
  end

  always_comb begin
    sb_in = '0;
    if (w_grant_rd)      sb_in = bus.rd_req_data;
    else if (w_grant_ks) sb_in = {{(AES_STATE_W-AES_WORD_W){1'b0}}, bus.ks_req_word};
  end

  assign bus.rd_req_ready = w_grant_rd;
  assign bus.ks_req_ready = w_grant_ks;

  always_comb begin
    w_tag_in     = '0;
    w_tag_in.vld = w_grant_rd | w_grant_ks;
    w_tag_in.id  = w_grant_ks ? ID_KS : ID_RD;
  end

  sbox_tag_pipe #(
    .DEPTH (SBOX_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // The tag leaving the pipe lines up with sb_out; route it to its issuer.
  assign bus.rd_rsp_valid = w_tag_out.vld && (w_tag_out.id == ID_RD);
  assign bus.ks_rsp_valid = w_tag_out.vld && (w_tag_out.id == ID_KS);
  assign bus.rd_rsp_data  = bus.rd_rsp_valid ? sb_out : '0;
  assign bus.ks_rsp_word  = bus.ks_rsp_valid ? sb_out[AES_WORD_W-1:0] : '0;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Self-checking bench for sbox_arbiter with a behavioural registered S-box.
// A negedge monitor predicts grants/sb_in, pushes expected results to a
// scoreboard on each handshake and pops them when a response pulse appears.
module tb_sbox_arbiter;
  import aes_pkg::*;

  localparam int LAT = 2;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    req_id_t      id;
    logic [127:0] data;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic [127:0] sb_pipe [LAT];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rsp_pulses = 0;

  exp_t         sb_q [$];
  req_id_t      grant_hist [$];
  logic [127:0] rd_hist [$];
  logic [31:0]  ks_hist [$];
  req_id_t      m_ptr = ID_KS;
  logic         m_exp_rd;
  logic         m_exp_ks;
  logic [127:0] m_exp_sb;
  exp_t         m_e;

  always #5 clk = ~clk;

  sbox_arbiter_if u_if ();

  sbox_arbiter #(
    .SBOX_LAT (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (u_if.slave),
    .sb_in  (sb_in),
    .sb_out (sb_out)
  );

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sub_byte(s[8*i +: 8]);
    return r;
  endfunction

  // Behavioural S-box with LAT register stages.
  always @(posedge clk) begin
    sb_pipe[0] <= sub_state(sb_in);
    for (int i = 1; i < LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
  end
  assign sb_out = sb_pipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_rd_ready", 128'(u_if.rd_req_ready), '0);
      check("rst_ks_ready", 128'(u_if.ks_req_ready), '0);
      check("rst_rd_rsp_valid", 128'(u_if.rd_rsp_valid), '0);
      check("rst_ks_rsp_valid", 128'(u_if.ks_rsp_valid), '0);
      check("rst_rd_rsp_data", u_if.rd_rsp_data, '0);
      check("rst_ks_rsp_word", 128'(u_if.ks_rsp_word), '0);
      check("rst_sb_in", sb_in, '0);
      sb_q.delete();
      m_ptr = ID_KS;
    end else begin
      // Responses
      if (u_if.rd_rsp_valid || u_if.ks_rsp_valid) begin
        rsp_pulses++;
        check("rsp_exclusive", 128'(u_if.rd_rsp_valid & u_if.ks_rsp_valid), '0);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 128'({u_if.rd_rsp_valid, u_if.ks_rsp_valid}), '0);
        end else begin
          m_e = sb_q.pop_front();
          check("rsp_cycle", 128'(cyc), 128'(m_e.due));
          if (m_e.id == ID_RD) begin
            check("rd_rsp_valid", 128'(u_if.rd_rsp_valid), 128'd1);
            check("rd_rsp_data", u_if.rd_rsp_data, m_e.data);
            check("ks_rsp_word_idle", 128'(u_if.ks_rsp_word), '0);
            rd_hist.push_back(u_if.rd_rsp_data);
          end else begin
            check("ks_rsp_valid", 128'(u_if.ks_rsp_valid), 128'd1);
            check("ks_rsp_word", 128'(u_if.ks_rsp_word), 128'(m_e.data[31:0]));
            check("rd_rsp_data_idle", u_if.rd_rsp_data, '0);
            ks_hist.push_back(u_if.ks_rsp_word);
          end
        end
      end else begin
        check("rd_rsp_data_idle", u_if.rd_rsp_data, '0);
        check("ks_rsp_word_idle", 128'(u_if.ks_rsp_word), '0);
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          check("rsp_missing", 128'(u_if.rd_rsp_valid | u_if.ks_rsp_valid), 128'd1);
          void'(sb_q.pop_front());
        end
      end
      // Grants and S-box operand
      m_exp_rd = u_if.rd_req_valid && !(u_if.ks_req_valid && m_ptr == ID_KS);
      m_exp_ks = u_if.ks_req_valid && !m_exp_rd;
      m_exp_sb = m_exp_rd ? u_if.rd_req_data :
                 m_exp_ks ? {96'h0, u_if.ks_req_word} : '0;
      check("rd_req_ready", 128'(u_if.rd_req_ready), 128'(m_exp_rd));
      check("ks_req_ready", 128'(u_if.ks_req_ready), 128'(m_exp_ks));
      check("sb_in", sb_in, m_exp_sb);
      if (m_exp_rd) begin
        sb_q.push_back('{ID_RD, sub_state(u_if.rd_req_data), cyc + LAT});
        grant_hist.push_back(ID_RD);
      end else if (m_exp_ks) begin
        sb_q.push_back('{ID_KS, sub_state({96'h0, u_if.ks_req_word}), cyc + LAT});
        grant_hist.push_back(ID_KS);
      end
      if (u_if.rd_req_valid && u_if.ks_req_valid) m_ptr = m_exp_ks ? ID_RD : ID_KS;
    end
  end

  // Holds the given request inputs for exactly one clock cycle.
  task automatic drive(input logic rv, input logic [127:0] rd, input logic kv, input logic [31:0] kw);
    u_if.rd_req_valid = rv;
    u_if.rd_req_data  = rd;
    u_if.ks_req_valid = kv;
    u_if.ks_req_word  = kw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int      p0;
  req_id_t cont_order [4] = '{ID_KS, ID_RD, ID_KS, ID_RD};

  initial begin
    u_if.rd_req_valid = 1'b0;
    u_if.rd_req_data  = '0;
    u_if.ks_req_valid = 1'b0;
    u_if.ks_req_word  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Contention straight after reset: KS first, then alternate.
    grant_hist.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, rand128(), 1'b1, $urandom);
    idle(LAT + 1);
    check("cont_grants", 128'(grant_hist.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("cont_grant_%0d", i), 128'(grant_hist[i]), 128'(cont_order[i]));

    // Idle: nothing granted, nothing returned.
    p0 = rsp_pulses;
    idle(10);
    check("idle_no_rsp", 128'(rsp_pulses - p0), '0);

    // Single round request with the known vector.
    rd_hist.delete();
    drive(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, '0);
    idle(LAT + 1);
    check("rd_vec_count", 128'(rd_hist.size()), 128'd1);
    check("rd_vec_data", rd_hist[0], 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Single key-expansion request with the known word.
    ks_hist.delete();
    drive(1'b0, '0, 1'b1, 32'hcf4f3c09);
    idle(LAT + 1);
    check("ks_vec_count", 128'(ks_hist.size()), 128'd1);
    check("ks_vec_word", 128'(ks_hist[0]), 128'h8a84eb01);

    // Back-to-back round requests.
    rd_hist.delete();
    drive(1'b1, '0, 1'b0, '0);
    drive(1'b1, {16{8'h11}}, 1'b0, '0);
    drive(1'b1, {16{8'hff}}, 1'b0, '0);
    idle(LAT + 1);
    check("b2b_count", 128'(rd_hist.size()), 128'd3);
    check("b2b_0", rd_hist[0], {16{8'h63}});
    check("b2b_1", rd_hist[1], {16{8'h82}});
    check("b2b_2", rd_hist[2], {16{8'h16}});

    // Reset mid-flight: leave the pointer on RD, accept an RD request,
    // then reset before its result returns.
    drive(1'b1, rand128(), 1'b1, $urandom);
    u_if.rd_req_valid = 1'b1;
    u_if.rd_req_data  = rand128();
    @(posedge clk);
    #1;
    p0 = rsp_pulses;
    u_if.rd_req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(LAT + 2);
    check("rst_flight_no_rsp", 128'(rsp_pulses - p0), '0);
    grant_hist.delete();
    drive(1'b1, rand128(), 1'b1, $urandom);
    check("rst_ptr_ks", 128'(grant_hist[0]), 128'(ID_KS));
    idle(LAT + 1);

    // Random mixed traffic with data changing while valid is held.
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)), $urandom);
    idle(LAT + 2);
    check("scoreboard_drained", 128'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sbox_arbiter.md
Name: sbox_arbiter

Overview:
- Shares one registered 128-bit S-box instance (`sbox`) in the AES-256-CTR core between two requesters.
  - Round datapath: SubBytes on a full 128-bit state.
  - Key-expansion unit: SubWord on one 32-bit word.
- Arbitrates per cycle and drives the S-box input.
- Tracks in-flight operations in a tag pipeline matched to the S-box latency, then routes each result back to the requester that issued it.

Parameters:
- SBOX_LAT, 1: clock cycles from `sb_in` sampled to `sb_out` valid. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- rd_req_valid  in  1  round datapath SubBytes request
- rd_req_ready  out  1  request accepted this cycle (grant)
- rd_req_data  in  128  state to substitute
- rd_rsp_valid  out  1  one-cycle pulse, SubBytes result valid
- rd_rsp_data  out  128  substituted state
- ks_req_valid  in  1  key-expansion SubWord request
- ks_req_ready  out  1  request accepted this cycle
- ks_req_word  in  32  word to substitute
- ks_rsp_valid  out  1  one-cycle pulse, SubWord result valid
- ks_rsp_word  out  32  substituted word
- sb_in  out  128  to `sbox` `s_in`
- sb_out  in  128  from `sbox` `s_o`

Behaviour:
- Reset (rst=0, async):
  - All tag-pipe stages invalid.
  - Priority pointer = KS.
  - All ready/valid outputs 0; rsp data 0; `sb_in` = 0.
  - Reset mid-operation discards in-flight operations; no response pulses for them after release.
- Grant (combinational from valids and pointer; handshake completes when valid & ready):
  - Only one requester valid: grant it.
  - Both valid: grant the one the pointer selects; pointer then flips to the other requester (round-robin).
  - Pointer updates only on a contested grant. Uncontested grants leave it unchanged.
  - Exactly one ready high at most per cycle. Ready never asserts without the matching valid.
- sb_in mux:
  - RD grant: `rd_req_data`.
  - KS grant: {96'h0, `ks_req_word`}.
  - No grant: 128'h0.
- Tag pipe: SBOX_LAT stages of {vld, id}.
  - Stage 0 loads {grant_any, grant_is_ks} each cycle.
  - Output stage produces the response.
- Latency: request accepted in cycle N → rsp_valid high in cycle N+SBOX_LAT for exactly one cycle.
- Throughput: one accept per cycle, fully pipelined. No response backpressure; consumers must accept the pulse.
- Response routing:
  - RD response: `rd_rsp_data` = `sb_out`.
  - KS response: `ks_rsp_word` = `sb_out`[31:0].
  - Data outputs are 0 whenever the matching valid is 0.
- Ordering: responses return in acceptance order; requests back-to-back from both sources interleave correctly.
- Requester may hold valid with changing data. Only data present in the grant cycle is used.

Decomposition:
- Shared package `aes_pkg`: constants AES_STATE_W=128, AES_WORD_W=32; enum req_id_t {ID_RD=0, ID_KS=1}; tag struct {vld, id}.
- One sub-module `sbox_tag_pipe` (parameter DEPTH=SBOX_LAT): SBOX_LAT-stage shift register with async active-low clear.
- `sbox` itself is instantiated at the parent level, not inside this block.

Test Plan:
- Round request only:
  - Stimulus: `rd_req_data`=00112233445566778899aabbccddeeff in cycle N.
  - Response: `rd_req_ready`=1 in cycle N; `rd_rsp_valid` pulse at N+SBOX_LAT with `rd_rsp_data`=638293c31bfc33f5c4eeacea4bc12816; `ks_rsp_valid` stays 0.
- KS request only:
  - Stimulus: `ks_req_word`=cf4f3c09.
  - Response: `sb_in`=0000…cf4f3c09; `ks_rsp_word`=8a84eb01 after SBOX_LAT cycles.
- Contention:
  - Stimulus: both valid continuously for 4 cycles right after reset.
  - Response: grants KS, RD, KS, RD; responses in the same order, each SBOX_LAT later, with correct data per requester.
- Back-to-back round requests:
  - Stimulus: RD valid 3 consecutive cycles with data 00…00, 11…11, ff…ff.
  - Response: 3 consecutive `rd_rsp_valid` pulses with data 63…63, 82…82, 16…16.
- Reset mid-flight:
  - Stimulus: accept an RD request, drop rst to 0 the next cycle, release after 2 cycles.
  - Response: no `rd_rsp_valid`/`ks_rsp_valid` pulse at any time; outputs 0 during reset; pointer = KS afterwards (first contested grant goes to KS).
- Idle:
  - Stimulus: no valids for 10 cycles.
  - Response: both readies 0, `sb_in`=0, no responses.
